// File: rtl/stoch_im2col_pkg.sv
// rtl/stoch_im2col_pkg.sv - shared types and helpers for the streaming signed im2col
// Purpose: row-kind enum, signed-bitstream zero constant, output-size and patch-index helpers.
// Ports: none (package).
package stoch_im2col_pkg;

  // Classification of the padded row currently at the head of the stream.
  typedef enum logic [1:0] {
    ROW_TOP_PAD,
    ROW_IMAGE,
    ROW_BOT_PAD
  } row_kind_t;

  // {p, m} pair for a stochastic zero: neither stream fires.
  localparam logic [1:0] SBIT_ZERO = 2'b00;

  function automatic int out_dim(input int in_sz, input int pad, input int k, input int stride);
    return (in_sz + 2 * pad - k) / stride + 1;
  endfunction

  // Bit position of (kernel row, kernel col, channel) inside one patch.
  function automatic int col_idx(input int kr, input int kc, input int ch, input int kh, input int kw);
    return kc + kr * kw + ch * kh * kw;
  endfunction

endpackage

// File: rtl/stoch_signed_row_patch.sv
// rtl/stoch_signed_row_patch.sv - combinational patch extraction from a KERNEL_H-row window
// Purpose: builds OUT_W horizontally padded, strided patches from the line window.
// Ports: win_p/win_m   window rows, index 0 = oldest row
//        patch_p/patch_m OUT_W patches of COL_WIDTH bits each
module stoch_signed_row_patch
  import stoch_im2col_pkg::*;
#(
  parameter int IM_WIDTH  = 12,
  parameter int CHANNELS  = 3,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_W     = 1,
  parameter int STRIDE_W  = 1,
  parameter int OUT_W     = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
  parameter int COL_WIDTH = KERNEL_H * KERNEL_W * CHANNELS
) (
  input  logic [KERNEL_H-1:0][IM_WIDTH-1:0][CHANNELS-1:0] win_p,
  input  logic [KERNEL_H-1:0][IM_WIDTH-1:0][CHANNELS-1:0] win_m,
  output logic [OUT_W-1:0][COL_WIDTH-1:0]                 patch_p,
  output logic [OUT_W-1:0][COL_WIDTH-1:0]                 patch_m
);

  // Image column feeding kernel column kc of output patch c (may fall in the pad).
  function automatic int src_col(input int c, input int kc);
    return c * STRIDE_W + kc - PAD_W;
  endfunction

  always_comb begin
    patch_p = '0;
    patch_m = '0;
    for (int c = 0; c < OUT_W; c++) begin
      for (int kr = 0; kr < KERNEL_H; kr++) begin
        for (int kc = 0; kc < KERNEL_W; kc++) begin
          for (int ch = 0; ch < CHANNELS; ch++) begin
            if (src_col(c, kc) >= 0 && src_col(c, kc) < IM_WIDTH) begin
              patch_p[c][col_idx(kr, kc, ch, KERNEL_H, KERNEL_W)] = win_p[kr][src_col(c, kc)][ch];
              patch_m[c][col_idx(kr, kc, ch, KERNEL_H, KERNEL_W)] = win_m[kr][src_col(c, kc)][ch];
            end else begin
              {patch_p[c][col_idx(kr, kc, ch, KERNEL_H, KERNEL_W)],
               patch_m[c][col_idx(kr, kc, ch, KERNEL_H, KERNEL_W)]} = SBIT_ZERO;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/stoch_signed_stream_im2col.sv
// rtl/stoch_signed_stream_im2col.sv - row-serial im2col for p/m stochastic bitstreams
// Purpose: keeps a KERNEL_H-row line window, injects top/bottom zero rows, emits one
//          registered row of OUT_W patches per output beat.
// Ports: CLK, RST (sync, active-high)
//        in_valid/in_ready, in_row_p/in_row_m   one image row per accepted beat
//        out_valid/out_ready, out_p/out_m        one output row of patches
//        out_row, out_last                       output row index, final-row flag
module stoch_signed_stream_im2col
  import stoch_im2col_pkg::*;
#(
  parameter int IM_HEIGHT = 12,
  parameter int IM_WIDTH  = 12,
  parameter int CHANNELS  = 3,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_H     = 1,
  parameter int PAD_W     = 1,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1,
  localparam int OUT_H     = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
  localparam int OUT_W     = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
  localparam int COL_WIDTH = KERNEL_H * KERNEL_W * CHANNELS,
  localparam int ROW_W     = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [IM_WIDTH-1:0][CHANNELS-1:0]    in_row_p,
  input  logic [IM_WIDTH-1:0][CHANNELS-1:0]    in_row_m,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_W-1:0][COL_WIDTH-1:0]      out_p,
  output logic [OUT_W-1:0][COL_WIDTH-1:0]      out_m,
  output logic [ROW_W-1:0]                     out_row,
  output logic                                 out_last
);

  localparam int PH_TOT = IM_HEIGHT + 2 * PAD_H;
  localparam int PW     = $clog2(PH_TOT + 1);
  localparam int OW     = $clog2(OUT_H + 1);
  localparam int SW     = (STRIDE_H > 1) ? $clog2(STRIDE_H) : 1;

  typedef logic [IM_WIDTH-1:0][CHANNELS-1:0] row_t;
  typedef logic [KERNEL_H-1:0][IM_WIDTH-1:0][CHANNELS-1:0] win_t;

  logic [PW-1:0] prow, prow_nxt;  // padded row index of the next row to shift in
  logic [OW-1:0] orow, orow_nxt;  // next output row index within the frame
  logic [SW-1:0] sph, sph_nxt;    // vertical stride phase once the window is full
  win_t          win_p, win_m, nwin_p, nwin_m;
  row_t          new_p, new_m;
  row_kind_t     kind;
  logic          advance, shift, produce;
  logic [OUT_W-1:0][COL_WIDTH-1:0] patch_p, patch_m;

  always_comb begin
    kind = ROW_IMAGE;
    if (int'(prow) < PAD_H) begin
      kind = ROW_TOP_PAD;
    end else if (int'(prow) >= PAD_H + IM_HEIGHT) begin
      kind = ROW_BOT_PAD;
    end

    advance  = !out_valid || out_ready;
    in_ready = !RST && advance && (kind == ROW_IMAGE);
    // Pad rows need no handshake; image rows wait for a beat.
    shift    = !RST && advance && ((kind != ROW_IMAGE) || in_valid);

    new_p = (kind == ROW_IMAGE) ? in_row_p : '0;
    new_m = (kind == ROW_IMAGE) ? in_row_m : '0;
    // Newest row enters at the top index, everything else moves one step older.
    nwin_p = {new_p, win_p[KERNEL_H-1:1]};
    nwin_m = {new_m, win_m[KERNEL_H-1:1]};

    // orow saturates at OUT_H, which suppresses output for trailing unused rows.
    produce = shift && (int'(prow) >= KERNEL_H - 1) && (sph == '0) && (int'(orow) < OUT_H);

    prow_nxt = prow;
    orow_nxt = orow;
    sph_nxt  = sph;
    if (shift) begin
      if (int'(prow) == PH_TOT - 1) begin
        prow_nxt = '0;
        orow_nxt = '0;
        sph_nxt  = '0;
      end else begin
        prow_nxt = prow + 1'b1;
        if (int'(prow) >= KERNEL_H - 1) begin
          sph_nxt = (int'(sph) == STRIDE_H - 1) ? '0 : sph + 1'b1;
          if (produce) begin
            orow_nxt = orow + 1'b1;
          end
        end
      end
    end
  end

  // Patches are taken from the post-shift window so the output lands one cycle after the shift.
  stoch_signed_row_patch #(
    .IM_WIDTH (IM_WIDTH),
    .CHANNELS (CHANNELS),
    .KERNEL_H (KERNEL_H),
    .KERNEL_W (KERNEL_W),
    .PAD_W    (PAD_W),
    .STRIDE_W (STRIDE_W),
    .OUT_W    (OUT_W),
    .COL_WIDTH(COL_WIDTH)
  ) u_patch (
    .win_p  (nwin_p),
    .win_m  (nwin_m),
    .patch_p(patch_p),
    .patch_m(patch_m)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      prow      <= '0;
      orow      <= '0;
      sph       <= '0;
      win_p     <= '0;
      win_m     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_p     <= '0;
      out_m     <= '0;
    end else begin
      prow <= prow_nxt;
      orow <= orow_nxt;
      sph  <= sph_nxt;
      if (shift) begin
        win_p <= nwin_p;
        win_m <= nwin_m;
      end
      if (produce) begin
        out_valid <= 1'b1;
        out_p     <= patch_p;
        out_m     <= patch_m;
        out_row   <= orow[ROW_W-1:0];
        out_last  <= (int'(orow) == OUT_H - 1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
